wb_bus_if: RTL and testbench
============================

# wb_bus_if

Wishbone classic-cycle master bridge between one OpenMIPS memory port (instruction or data) and the system Wishbone bus. It is instantiated twice, on the downstream side of the core's `rom_*` and `ram_*` ports. While a bus transaction is pending it holds the pipeline through `stallreq_o` into `ctrl`. Read data returned during a stall is buffered until the pipeline releases.

## Interface
Parameters:
- `DW`, default 32: data width.
- `AW`, default 32: address width.
- `SW`, default `DW/8`: byte-select width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_i`  in  6  pipeline stall vector from `ctrl`.
- `flush_i`  in  1  pipeline flush; abandons the current transaction.
- `cpu_ce_i`  in  1  access request from the core.
- `cpu_we_i`  in  1  1 = write, 0 = read.
- `cpu_addr_i`  in  AW  byte address.
- `cpu_data_i`  in  DW  write data.
- `cpu_sel_i`  in  SW  byte enables.
- `cpu_data_o`  out  DW  read data to the core.
- `stallreq_o`  out  1  stall request to `ctrl`.
- `wishbone_data_i`  in  DW  slave read data.
- `wishbone_ack_i`  in  1  slave acknowledge.
- `wishbone_addr_o`  out  AW  bus address.
- `wishbone_data_o`  out  DW  bus write data.
- `wishbone_we_o`  out  1  bus write enable.
- `wishbone_sel_o`  out  SW  bus byte selects.
- `wishbone_stb_o`  out  1  strobe.
- `wishbone_cyc_o`  out  1  cycle valid.

## Operation
- Three-state FSM: IDLE, BUSY, WAIT_STALL.
- Registered outputs: all `wishbone_*_o`, plus read buffer `rd_buf`.
- Combinational outputs: `cpu_data_o` and `stallreq_o`.
- IDLE:
  - If `cpu_ce_i && !flush_i`: register addr/data/we/sel onto the bus, set `cyc=stb=1`, go to BUSY.
  - `stallreq_o = cpu_ce_i && !flush_i`.
  - `cpu_data_o = 0`.
- BUSY:
  - On `wishbone_ack_i`:
    - Clear `cyc`, `stb`, `we`, `sel`, `addr`, `data` to 0.
    - If `!cpu_we_i`, load `rd_buf <= wishbone_data_i`.
    - Go to WAIT_STALL if `stall_i != 0`, else IDLE.
  - Combinational in the ack cycle: `stallreq_o = 0`, `cpu_data_o = wishbone_data_i`.
  - Without ack: `stallreq_o = 1`, `cpu_data_o = 0`.
- WAIT_STALL:
  - `stallreq_o = 0`, `cpu_data_o = rd_buf`.
  - Go to IDLE when `stall_i == 0`.
- Flush:
  - `flush_i` in any state forces IDLE next cycle and clears all bus outputs and `rd_buf`.
  - Flush takes priority over a same-cycle ack; the ack data is discarded.
- `wishbone_ack_i` in IDLE or WAIT_STALL is ignored.
- Single classic cycles only. No bursts, no ERR/RTY, no timeout; BUSY waits indefinitely.
- Writes: `rd_buf` is unchanged; `cpu_data_o` in WAIT_STALL still shows `rd_buf` (don't-care to the core).

## Timing
- Reset: state IDLE; `rd_buf` and every registered output = 0. `stallreq_o` and `cpu_data_o` are 0 while `rst=1`.
- Request in IDLE at cycle N: `stallreq_o=1` in cycle N; `cyc`/`stb` visible from cycle N+1.
- Zero-wait slave (ack in N+1): data and `stallreq_o=0` in cycle N+1; bus idle at N+2. Minimum latency: one extra cycle.
- K wait states: `stallreq_o` stays high through cycle N+K; ack arrives at N+1+K.
- Bus outputs hold stable for the whole of BUSY. `stb` always equals `cyc`.
- Back-to-back: a new request is accepted the first cycle the FSM is back in IDLE. There are no idle gaps beyond this.
- Reset mid-BUSY: `cyc`/`stb` drop on the next edge; any later ack is ignored.

## Structure
- State codes `WB_IDLE` (2'b00), `WB_BUSY` (2'b01), `WB_WAIT_STALL` (2'b10) go in `defines.v`.
- Widths reuse `RegBus`.
- Single flat module; no sub-module.
- Top level changes:
  - Two instances in the SoC wrapper.
  - `ctrl` gains `stallreq_from_if` and `stallreq_from_mem` inputs.

## Test plan
- Reset: assert `rst` with `cpu_ce_i=1` -> all outputs 0, state IDLE; after release, `cyc` rises one cycle later.
- Zero-wait read, addr 0x100, slave returns 0xDEADBEEF on the first cycle `cyc` is high -> `stallreq_o` high exactly 1 cycle; `cpu_data_o=0xDEADBEEF` in the ack cycle; `cyc` low next cycle.
- Write with 3 wait states, addr 0x200, data 0x12345678, sel 4'b0011 -> bus fields stable for 4 cycles; `stallreq_o` high 4 cycles; `we` cleared after ack.
- Read acked while `stall_i=6'b000111` held 2 more cycles -> WAIT_STALL; `cpu_data_o=rd_buf` throughout; return to IDLE when `stall_i=0`.
- `flush_i` in 2nd BUSY cycle, same cycle as ack -> IDLE next cycle; `rd_buf=0`; ack data not presented.
- Spurious ack in IDLE -> no state change, outputs remain 0.

Source files
------------

// File: rtl/wb_bus_if_pkg.sv
// wb_bus_if_pkg: shared types and constants for the Wishbone master bridge.
//   RegBus      - default data/address width of the core's memory ports.
//   wb_state_e  - bridge FSM state encoding (idle, busy on the bus, holding
//                 read data while the pipeline is stalled).
//   stall_any   - true when any bit of the pipeline stall vector is set.
package wb_bus_if_pkg;

  localparam int unsigned RegBus = 32;

  typedef enum logic [1:0] {
    WbIdle      = 2'b00,
    WbBusy      = 2'b01,
    WbWaitStall = 2'b10
  } wb_state_e;

  function automatic logic stall_any(input logic [5:0] stall);
    return |stall;
  endfunction

endpackage

// File: rtl/wb_bus_if_if.sv
// wb_bus_if_if: Wishbone classic-cycle bus bundle between the bridge and a slave.
//   wishbone_data_i  slave -> master  read data
//   wishbone_ack_i   slave -> master  acknowledge
//   wishbone_addr_o  master -> slave  byte address
//   wishbone_data_o  master -> slave  write data
//   wishbone_we_o    master -> slave  write enable
//   wishbone_sel_o   master -> slave  byte selects
//   wishbone_stb_o   master -> slave  strobe
//   wishbone_cyc_o   master -> slave  cycle valid
// Signal names keep the master's point of view so they line up with the bridge.
interface wb_bus_if_if
  import wb_bus_if_pkg::*;
#(
  parameter int unsigned DW = RegBus,
  parameter int unsigned AW = RegBus,
  parameter int unsigned SW = DW / 8
) ();

  logic [DW-1:0] wishbone_data_i;
  logic          wishbone_ack_i;
  logic [AW-1:0] wishbone_addr_o;
  logic [DW-1:0] wishbone_data_o;
  logic          wishbone_we_o;
  logic [SW-1:0] wishbone_sel_o;
  logic          wishbone_stb_o;
  logic          wishbone_cyc_o;

  modport master (
    input  wishbone_data_i,
    input  wishbone_ack_i,
    output wishbone_addr_o,
    output wishbone_data_o,
    output wishbone_we_o,
    output wishbone_sel_o,
    output wishbone_stb_o,
    output wishbone_cyc_o
  );

  modport slave (
    output wishbone_data_i,
    output wishbone_ack_i,
    input  wishbone_addr_o,
    input  wishbone_data_o,
    input  wishbone_we_o,
    input  wishbone_sel_o,
    input  wishbone_stb_o,
    input  wishbone_cyc_o
  );

endinterface

// File: rtl/wb_bus_if.sv
// wb_bus_if: Wishbone classic-cycle master bridge for one core memory port.
// Holds the pipeline via stallreq_o while a bus access is outstanding and
// buffers read data returned while the pipeline is stalled.
//   clk, rst     clock and synchronous active-high reset
//   stall_i      pipeline stall vector from ctrl
//   flush_i      pipeline flush; abandons any transaction in flight
//   cpu_*_i      access request from the core (ce, we, addr, data, sel)
//   cpu_data_o   read data to the core (combinational)
//   stallreq_o   stall request to ctrl (combinational)
//   wb           Wishbone master side of the bus (outputs registered)
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int unsigned DW = RegBus,
  parameter int unsigned AW = RegBus,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall_i,
  input  logic          flush_i,
  input  logic          cpu_ce_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  input  logic [SW-1:0] cpu_sel_i,
  output logic [DW-1:0] cpu_data_o,
  output logic          stallreq_o,
  wb_bus_if_if.master   wb
);

  wb_state_e     state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          we_q;
  logic [SW-1:0] sel_q;
  logic          cyc_q;
  logic [DW-1:0] rd_buf_q;

  // Flush behaves like reset for the bridge: the access is dropped, the bus
  // is released and any buffered read data is discarded.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q  <= WbIdle;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      case (state_q)
        WbIdle: begin
          if (cpu_ce_i) begin
            addr_q  <= cpu_addr_i;
            data_q  <= cpu_data_i;
            we_q    <= cpu_we_i;
            sel_q   <= cpu_sel_i;
            cyc_q   <= 1'b1;
            state_q <= WbBusy;
          end
        end
        WbBusy: begin
          if (wb.wishbone_ack_i) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cyc_q  <= 1'b0;
            if (!cpu_we_i) begin
              rd_buf_q <= wb.wishbone_data_i;
            end
            state_q <= stall_any(stall_i) ? WbWaitStall : WbIdle;
          end
        end
        WbWaitStall: begin
          if (!stall_any(stall_i)) begin
            state_q <= WbIdle;
          end
        end
        default: state_q <= WbIdle;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state_q)
        WbIdle: begin
          stallreq_o = cpu_ce_i && !flush_i;
        end
        WbBusy: begin
          if (wb.wishbone_ack_i) begin
            // A flush in the ack cycle discards the data; never forward it.
            cpu_data_o = flush_i ? '0 : wb.wishbone_data_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        WbWaitStall: begin
          cpu_data_o = rd_buf_q;
        end
        default: ;
      endcase
    end
  end

  // stb is tied to cyc: only single classic cycles are issued.
  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_cyc_o  = cyc_q;
  assign wb.wishbone_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_bus_if.sv
// tb_wb_bus_if: self-checking bench for wb_bus_if (directed cycle table,
// hand-written corner sequences, randomized run against a transaction model).
module tb_wb_bus_if;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] cpu_data;
  logic        stallreq;

  int n_checks = 0;
  int n_pass   = 0;

  wb_bus_if_if #(.DW(32), .AW(32), .SW(4)) bus ();

  wb_bus_if #(.DW(32), .AW(32), .SW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_ce_i   (ce),
    .cpu_we_i   (we),
    .cpu_addr_i (addr),
    .cpu_data_i (wdata),
    .cpu_sel_i  (sel),
    .cpu_data_o (cpu_data),
    .stallreq_o (stallreq),
    .wb         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stallreq;
    logic [31:0] data;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [5:0]  stall;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic r, input logic c, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [5:0] st, input logic f, input logic k,
                              input logic [31:0] rd, input logic esr, input logic [31:0] edat,
                              input logic ecyc, input logic ewe, input logic [31:0] eaddr,
                              input logic [31:0] ewd, input logic [3:0] esel);
    vec_t v;
    v.name  = name;
    v.rst   = r;
    v.ce    = c;
    v.we    = w;
    v.addr  = a;
    v.wdata = d;
    v.sel   = s;
    v.stall = st;
    v.flush = f;
    v.ack   = k;
    v.rdata = rd;
    v.exp   = '{stallreq: esr, data: edat, cyc: ecyc, stb: ecyc, we: ewe, addr: eaddr,
                wdata: ewd, sel: esel};
    return v;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = '{stallreq: stallreq, data: cpu_data, cyc: bus.wishbone_cyc_o,
            stb: bus.wishbone_stb_o, we: bus.wishbone_we_o, addr: bus.wishbone_addr_o,
            wdata: bus.wishbone_data_o, sel: bus.wishbone_sel_o};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got sr=%b dat=%h cyc=%b stb=%b we=%b adr=%h wd=%h sel=%h ; want sr=%b dat=%h cyc=%b stb=%b we=%b adr=%h wd=%h sel=%h",
               name, act.stallreq, act.data, act.cyc, act.stb, act.we, act.addr, act.wdata,
               act.sel, exp.stallreq, exp.data, exp.cyc, exp.stb, exp.we, exp.addr, exp.wdata,
               exp.sel);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check mid-cycle; the
  // rising edge that consumes these inputs follows.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst                 = v.rst;
    ce                  = v.ce;
    we                  = v.we;
    addr                = v.addr;
    wdata               = v.wdata;
    sel                 = v.sel;
    stall               = v.stall;
    flush               = v.flush;
    bus.wishbone_ack_i  = v.ack;
    bus.wishbone_data_i = v.rdata;
    #2;
    check(v.name, v.exp);
  endtask

  // Transaction-level reference: a pending access record plus a held read word.
  bit          m_pend;
  bit          m_hold;
  logic [31:0] m_held;
  out_t        m_req;

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    stall = '0; flush = 1'b0;
    bus.wishbone_ack_i = 1'b0;
    bus.wishbone_data_i = '0;

    // name rst ce we addr wdata sel stall flush ack rdata | sr data cyc we addr wdata sel
    tbl.push_back(mk("rst_ce", 1, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst_hold", 1, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("zw_req", 0, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("zw_ack", 0, 1, 0, 32'h100, 0, 4'hF, 0, 0, 1, 32'hDEADBEEF,
                     0, 32'hDEADBEEF, 1, 0, 32'h100, 0, 4'hF));
    tbl.push_back(mk("zw_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wr_req", 0, 1, 1, 32'h200, 32'h12345678, 4'h3, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(mk($sformatf("wr_ws%0d", i), 0, 1, 1, 32'h200, 32'h12345678, 4'h3, 0, 0,
                       0, 0, 1, 0, 1, 1, 32'h200, 32'h12345678, 4'h3));
    end
    tbl.push_back(mk("wr_ack", 0, 1, 1, 32'h200, 32'h12345678, 4'h3, 0, 0, 1, 32'h55AA55AA,
                     0, 32'h55AA55AA, 1, 1, 32'h200, 32'h12345678, 4'h3));
    tbl.push_back(mk("wr_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rs_req", 0, 1, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rs_ack", 0, 1, 0, 32'h300, 0, 4'hF, 6'h07, 0, 1, 32'hCAFEF00D,
                     0, 32'hCAFEF00D, 1, 0, 32'h300, 0, 4'hF));
    tbl.push_back(mk("rs_wait1", 0, 1, 0, 32'h300, 0, 4'hF, 6'h07, 0, 0, 0,
                     0, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rs_wait2", 0, 1, 0, 32'h300, 0, 4'hF, 6'h07, 0, 0, 0,
                     0, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rs_release", 0, 1, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0,
                     0, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rs_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("fl_req", 0, 1, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("fl_busy1", 0, 1, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0,
                     1, 0, 1, 0, 32'h400, 0, 4'hF));
    tbl.push_back(mk("fl_ack", 0, 1, 0, 32'h400, 0, 4'hF, 6'h07, 1, 1, 32'h87654321,
                     0, 0, 1, 0, 32'h400, 0, 4'hF));
    tbl.push_back(mk("fl_after", 0, 0, 0, 0, 0, 0, 6'h07, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rb_req", 0, 1, 1, 32'h500, 32'h1, 4'hF, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rb_ack", 0, 1, 1, 32'h500, 32'h1, 4'hF, 6'h01, 0, 1, 32'hA5A5A5A5,
                     0, 32'hA5A5A5A5, 1, 1, 32'h500, 32'h1, 4'hF));
    tbl.push_back(mk("rb_wait", 0, 1, 1, 32'h500, 32'h1, 4'hF, 6'h01, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rb_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sp_ack1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,
                     0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sp_ack2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF,
                     0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset while BUSY: bus drops on the next edge, a late ack is ignored.
    apply(mk("rm_req", 0, 1, 0, 32'h600, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("rm_busy", 0, 1, 0, 32'h600, 0, 4'hF, 0, 0, 0, 0, 1, 0, 1, 0, 32'h600, 0, 4'hF));
    apply(mk("rm_rst", 1, 1, 0, 32'h600, 0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0, 32'h600, 0, 4'hF));
    apply(mk("rm_late_ack", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13579BDF, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("rm_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Back-to-back: next request accepted the first cycle back in IDLE.
    apply(mk("bb_req1", 0, 1, 0, 32'h700, 0, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("bb_ack1", 0, 1, 0, 32'h700, 0, 4'hF, 0, 0, 1, 32'h11111111,
             0, 32'h11111111, 1, 0, 32'h700, 0, 4'hF));
    apply(mk("bb_req2", 0, 1, 1, 32'h704, 32'hABCD, 4'h1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("bb_ack2", 0, 1, 1, 32'h704, 32'hABCD, 4'h1, 0, 0, 1, 32'h2222,
             0, 32'h2222, 1, 1, 32'h704, 32'hABCD, 4'h1));
    apply(mk("bb_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized run against the transaction model.
    m_pend = 1'b0;
    m_hold = 1'b0;
    m_held = '0;
    m_req  = '0;
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      out_t e;
      @(negedge clk);
      rst   = (cyc_n == 0) || ($urandom_range(0, 63) == 0);
      ce    = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      sel   = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      flush = ($urandom_range(0, 15) == 0);
      bus.wishbone_ack_i  = ($urandom_range(0, 9) < 4);
      bus.wishbone_data_i = $urandom;
      #2;

      e = '0;
      if (m_pend) e = m_req;
      if (!rst) begin
        if (m_pend) begin
          if (bus.wishbone_ack_i) e.data = flush ? 32'h0 : bus.wishbone_data_i;
          else e.stallreq = 1'b1;
        end else if (m_hold) begin
          e.data = m_held;
        end else begin
          e.stallreq = ce && !flush;
        end
      end
      check($sformatf("rand%0d", cyc_n), e);

      if (rst || flush) begin
        m_pend = 1'b0;
        m_hold = 1'b0;
        m_held = '0;
      end else if (m_pend) begin
        if (bus.wishbone_ack_i) begin
          m_pend = 1'b0;
          if (!we) m_held = bus.wishbone_data_i;
          m_hold = (stall != 6'd0);
        end
      end else if (m_hold) begin
        m_hold = (stall != 6'd0);
      end else if (ce) begin
        m_pend = 1'b1;
        m_req  = '{stallreq: 1'b0, data: 32'h0, cyc: 1'b1, stb: 1'b1, we: we, addr: addr,
                   wdata: wdata, sel: sel};
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
